// File: rtl/dma_cache_port_if.sv
// Bus bundle between the DMA engine, the DMA-to-cache port and the cache.
// The slave modport is the port block's view; master is the environment's view.
interface dma_cache_port_if #(
    parameter int N_LANE      = 4,
    parameter int LANE_W      = 64,
    parameter int ADDR_W      = 40,
    parameter int TID_W       = 7,
    parameter int CACHE_TID_W = 12,
    parameter int TYPE_W      = 4,
    parameter int MAX_OUTST   = 4
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // DMA request side
    logic                         req_valid;
    logic                         req_ready;
    logic [ADDR_W-1:0]            req_addr;
    logic [LANE_W-1:0]            req_wdata;
    logic [LANE_W/8-1:0]          req_mask;
    logic [TID_W-1:0]             req_tid;
    logic [TYPE_W-1:0]            req_type;
    logic                         req_is_wr;

    // cache request side
    logic                         cache_req_valid;
    logic                         cache_req_ready;
    logic [ADDR_W-1:0]            cache_req_paddr;
    logic [N_LANE*LANE_W-1:0]     cache_req_data;
    logic [N_LANE*LANE_W/8-1:0]   cache_req_mask;
    logic [CACHE_TID_W-1:0]       cache_req_tid;
    logic [TYPE_W-1:0]            cache_req_type;

    // cache response side
    logic                         cache_rsp_valid;
    logic                         cache_rsp_ready;
    logic [N_LANE*LANE_W-1:0]     cache_rsp_data;
    logic [CACHE_TID_W-1:0]       cache_rsp_tid;

    // DMA response side
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [LANE_W-1:0]            rsp_rdata;
    logic [TID_W-1:0]             rsp_tid;
    logic                         rsp_is_wr;

    // status
    logic [CNT_W-1:0]             outst_cnt;
    logic                         err_tid_mismatch;
    logic                         err_unexp_rsp;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_mask, req_tid, req_type, req_is_wr,
        output req_ready,
        output cache_req_valid, cache_req_paddr, cache_req_data, cache_req_mask,
               cache_req_tid, cache_req_type,
        input  cache_req_ready,
        input  cache_rsp_valid, cache_rsp_data, cache_rsp_tid,
        output cache_rsp_ready,
        output rsp_valid, rsp_rdata, rsp_tid, rsp_is_wr,
        input  rsp_ready,
        output outst_cnt, err_tid_mismatch, err_unexp_rsp
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_mask, req_tid, req_type, req_is_wr,
        input  req_ready,
        input  cache_req_valid, cache_req_paddr, cache_req_data, cache_req_mask,
               cache_req_tid, cache_req_type,
        output cache_req_ready,
        output cache_rsp_valid, cache_rsp_data, cache_rsp_tid,
        input  cache_rsp_ready,
        input  rsp_valid, rsp_rdata, rsp_tid, rsp_is_wr,
        output rsp_ready,
        input  outst_cnt, err_tid_mismatch, err_unexp_rsp
    );
endinterface

// File: rtl/dma_cache_port.sv
// DMA-to-cache port: steers a single-lane DMA access into one lane of a wide
// cache access, tracks outstanding transactions in order, and returns the
// selected lane of each cache response through a small response FIFO.
module dma_cache_port #(
    parameter int N_LANE      = 4,
    parameter int LANE_W      = 64,
    parameter int ADDR_W      = 40,
    parameter int TID_W       = 7,
    parameter int CACHE_TID_W = 12,
    parameter int TYPE_W      = 4,
    parameter int MAX_OUTST   = 4,
    parameter int RSP_DEPTH   = 2
) (
    input  logic             clk,
    input  logic             rstn,
    dma_cache_port_if.slave  bus
);
    localparam int MASK_W = LANE_W / 8;
    localparam int OFF    = $clog2(MASK_W);
    localparam int LIW    = (N_LANE > 1) ? $clog2(N_LANE) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int TP_W   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int RC_W   = $clog2(RSP_DEPTH + 1);
    localparam int RP_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    // tracker FIFO state
    logic [TID_W-1:0]  trk_tid_q  [MAX_OUTST];
    logic [LIW-1:0]    trk_lane_q [MAX_OUTST];
    logic              trk_wr_q   [MAX_OUTST];
    logic [TP_W-1:0]   trk_wp, trk_rp;
    logic [CNT_W-1:0]  trk_cnt;

    // response FIFO state
    logic [LANE_W-1:0] rsp_data_q [RSP_DEPTH];
    logic [TID_W-1:0]  rsp_tid_q  [RSP_DEPTH];
    logic              rsp_wr_q   [RSP_DEPTH];
    logic [RP_W-1:0]   rsp_wp, rsp_rp;
    logic [RC_W-1:0]   rsp_cnt;

    logic [LIW-1:0]    lane;
    logic              trk_full, trk_empty, trk_push, trk_pop;
    logic              rsp_full, rsp_push, rsp_pop, rsp_acc, stray;
    logic              req_ready_int, cache_rsp_ready_int, rsp_valid_int;
    logic [N_LANE*LANE_W-1:0] req_data;
    logic [N_LANE*MASK_W-1:0] req_mask;
    logic [LANE_W-1:0] head_lane_data;
    logic              unused_rsp_tid_hi;

    function automatic logic [TP_W-1:0] trk_next(input logic [TP_W-1:0] p);
        return (p == TP_W'(MAX_OUTST - 1)) ? '0 : p + TP_W'(1);
    endfunction

    function automatic logic [RP_W-1:0] rsp_next(input logic [RP_W-1:0] p);
        return (p == RP_W'(RSP_DEPTH - 1)) ? '0 : p + RP_W'(1);
    endfunction

    // lane index comes from the address bits just above the in-lane byte offset
    generate
        if (N_LANE > 1) begin : g_lane
            assign lane = bus.req_addr[OFF +: LIW];
        end else begin : g_lane_single
            assign lane = '0;
        end
    endgenerate

    // only the low TID_W bits of the returned cache tid are meaningful here
    assign unused_rsp_tid_hi = ^bus.cache_rsp_tid;

    assign trk_full  = (trk_cnt == CNT_W'(MAX_OUTST));
    assign trk_empty = (trk_cnt == '0);
    assign rsp_full  = (rsp_cnt == RC_W'(RSP_DEPTH));
    assign rsp_valid_int = (rsp_cnt != '0);

    // handshakes are gated by rstn so nothing is offered or accepted in reset;
    // a full tracker blocks new requests even if it pops this cycle
    assign req_ready_int       = rstn & bus.cache_req_ready & ~trk_full;
    assign cache_rsp_ready_int = rstn & (trk_empty | ~rsp_full | bus.rsp_ready);

    assign trk_push = bus.req_valid & req_ready_int;
    assign rsp_acc  = bus.cache_rsp_valid & cache_rsp_ready_int;
    assign trk_pop  = rsp_acc & ~trk_empty;
    assign stray    = rsp_acc & trk_empty;
    assign rsp_push = trk_pop;
    assign rsp_pop  = rsp_valid_int & bus.rsp_ready;

    // place write data and byte enables into the addressed lane, zero elsewhere
    always_comb begin
        req_data = '0;
        req_mask = '0;
        for (int i = 0; i < N_LANE; i++) begin
            if (lane == LIW'(i)) begin
                req_data[i*LANE_W +: LANE_W] = bus.req_wdata;
                req_mask[i*MASK_W +: MASK_W] = bus.req_mask;
            end
        end
    end

    // pick the lane recorded for the oldest outstanding transaction
    always_comb begin
        head_lane_data = '0;
        for (int i = 0; i < N_LANE; i++) begin
            if (trk_lane_q[trk_rp] == LIW'(i)) begin
                head_lane_data = bus.cache_rsp_data[i*LANE_W +: LANE_W];
            end
        end
    end

    assign bus.req_ready       = req_ready_int;
    assign bus.cache_req_valid = rstn & bus.req_valid & ~trk_full;
    assign bus.cache_req_paddr = bus.req_addr;
    assign bus.cache_req_data  = req_data;
    assign bus.cache_req_mask  = req_mask;
    assign bus.cache_req_tid   = CACHE_TID_W'(bus.req_tid);
    assign bus.cache_req_type  = bus.req_type;
    assign bus.cache_rsp_ready = cache_rsp_ready_int;
    assign bus.rsp_valid       = rsp_valid_int;
    assign bus.rsp_rdata       = rsp_data_q[rsp_rp];
    assign bus.rsp_tid         = rsp_tid_q[rsp_rp];
    assign bus.rsp_is_wr       = rsp_wr_q[rsp_rp];
    assign bus.outst_cnt       = trk_cnt;

    // tracker pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trk_wp  <= '0;
            trk_rp  <= '0;
            trk_cnt <= '0;
        end else begin
            if (trk_push) trk_wp <= trk_next(trk_wp);
            if (trk_pop)  trk_rp <= trk_next(trk_rp);
            case ({trk_push, trk_pop})
                2'b10:   trk_cnt <= trk_cnt + CNT_W'(1);
                2'b01:   trk_cnt <= trk_cnt - CNT_W'(1);
                default: trk_cnt <= trk_cnt;
            endcase
        end
    end

    // tracker storage: tid, lane and direction of each accepted request
    always_ff @(posedge clk) begin
        if (trk_push) begin
            trk_tid_q[trk_wp]  <= bus.req_tid;
            trk_lane_q[trk_wp] <= lane;
            trk_wr_q[trk_wp]   <= bus.req_is_wr;
        end
    end

    // response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (rsp_push) rsp_wp <= rsp_next(rsp_wp);
            if (rsp_pop)  rsp_rp <= rsp_next(rsp_rp);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt <= rsp_cnt + RC_W'(1);
                2'b01:   rsp_cnt <= rsp_cnt - RC_W'(1);
                default: rsp_cnt <= rsp_cnt;
            endcase
        end
    end

    // response FIFO storage: payload always comes from the tracker head
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_data_q[rsp_wp] <= head_lane_data;
            rsp_tid_q[rsp_wp]  <= trk_tid_q[trk_rp];
            rsp_wr_q[rsp_wp]   <= trk_wr_q[trk_rp];
        end
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.err_tid_mismatch <= 1'b0;
            bus.err_unexp_rsp    <= 1'b0;
        end else begin
            if (trk_pop && (bus.cache_rsp_tid[TID_W-1:0] != trk_tid_q[trk_rp]))
                bus.err_tid_mismatch <= 1'b1;
            if (stray)
                bus.err_unexp_rsp <= 1'b1;
        end
    end
endmodule
